// File: rtl/clk_cross_pulse_feeder.sv
// Source-domain feeder for the gray-pointer pulse synchronizer write side.
// Optional stall statistics: define CLK_CROSS_FEED_STALL_CNT_EN.
module clk_cross_pulse_feeder #(
    parameter int EW      = 2,
    parameter int CW      = 8,
    parameter int MIN_GAP = 2
) (
    input  logic          clkin,
    input  logic          clr_in,
    input  logic [EW-1:0] evt_cnt,
    input  logic          flush,
    input  logic          xfull,
    output logic          sig_out,
    output logic [CW-1:0] pending,
    output logic          busy,
    output logic          ovf,
    output logic [15:0]   stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        GAP
    } state_t;

    localparam logic [CW:0] MAXV   = {1'b0, {CW{1'b1}}};
    localparam logic [3:0]  GAP_LD = 4'(MIN_GAP);

    if (MIN_GAP < 2 || MIN_GAP > 15) begin : g_bad_gap
        $error("MIN_GAP must be within 2..15");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] pend_q, pend_d;
    logic [3:0]    gap_q, gap_d;
    logic          sig_q, sig_d;
    logic          ovf_q, ovf_d;
    logic          issue;
    logic [CW:0]   sum;

    // Accumulate events, meter out pulses and pace them with the gap counter.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        sig_d   = 1'b0;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        issue   = (state_q == ARM) && !xfull && !flush;
        sum     = {1'b0, pend_q}
                + {{(CW + 1 - EW){1'b0}}, evt_cnt}
                - {{CW{1'b0}}, issue};
        if (flush) begin
            pend_d = '0;
        end else if (sum > MAXV) begin
            pend_d = '1;
            ovf_d  = 1'b1;
        end else begin
            pend_d = sum[CW-1:0];
        end
        case (state_q)
            IDLE: begin
                if (pend_d != '0) state_d = ARM;
            end
            ARM: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (issue) begin
                    sig_d   = 1'b1;
                    gap_d   = GAP_LD;
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1) begin
                    gap_d   = '0;
                    state_d = (pend_d != '0) ? ARM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset overriding everything.
    always_ff @(posedge clkin) begin
        if (clr_in) begin
            state_q <= IDLE;
            pend_q  <= '0;
            gap_q   <= '0;
            sig_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            sig_q   <= sig_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef CLK_CROSS_FEED_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Count cycles spent waiting in ARM on a full synchronizer.
    always_comb begin
        stall_d = stall_q;
        if (state_q == ARM && xfull && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clkin) begin
        if (clr_in) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign sig_out = sig_q;
    assign pending = pend_q;
    assign ovf     = ovf_q;
    assign busy    = (pend_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_clk_cross_pulse_feeder.sv
// Scoreboard bench for clk_cross_pulse_feeder with a timing-rule model.
// Stall expectations follow CLK_CROSS_FEED_STALL_CNT_EN.
module tb_clk_cross_pulse_feeder;

    localparam int EW      = 2;
    localparam int CW      = 4;
    localparam int MIN_GAP = 2;
    localparam int MAXP    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clr_in = 1'b1;
    logic [EW-1:0] evt_cnt = '0;
    logic          flush = 1'b0;
    logic          xfull = 1'b0;
    logic          sig_out;
    logic [CW-1:0] pending;
    logic          busy;
    logic          ovf;
    logic [15:0]   stall_cnt;

    clk_cross_pulse_feeder #(
        .EW(EW), .CW(CW), .MIN_GAP(MIN_GAP)
    ) dut (
        .clkin(clk), .clr_in(clr_in), .evt_cnt(evt_cnt),
        .flush(flush), .xfull(xfull), .sig_out(sig_out),
        .pending(pending), .busy(busy), .ovf(ovf),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;
    int exp_q[$];

    // model state: start-of-cycle view
    int pend = 0;
    int m_ovf = 0;
    int m_stall = 0;
    int earliest = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // pulse monitor: a pulse is due exactly when the queue head names this cycle
    always @(negedge clk) begin
        bit due;
        if (started) begin
            due = (exp_q.size() > 0) && (exp_q[0] == cyc);
            chk("sig_out", int'(sig_out), int'(due));
            if (due) void'(exp_q.pop_front());
        end
    end

    task automatic step(input bit r, input int e, input bit f, input bit x);
        bit armed;
        bit dec;
        int s;
        @(negedge clk);
        chk("pending", int'(pending), pend);
        chk("ovf", int'(ovf), m_ovf);
        chk("busy", int'(busy), int'(pend > 0 || cyc < earliest));
        chk("stall_cnt", int'(stall_cnt), m_stall);
        clr_in  = r;
        evt_cnt = e[EW-1:0];
        flush   = f;
        xfull   = x;
        if (r) begin
            pend = 0; m_ovf = 0; m_stall = 0; earliest = 0;
        end else begin
            armed = (pend > 0) && (cyc >= earliest);
`ifdef CLK_CROSS_FEED_STALL_CNT_EN
            if (armed && x && m_stall < 65535) m_stall++;
`endif
            dec = armed && !x && !f;
            if (dec) begin
                exp_q.push_back(cyc + 1);
                earliest = cyc + MIN_GAP + 1;
            end
            if (f) begin
                pend = 0;
            end else begin
                s = pend + (e % (1 << EW)) - int'(dec);
                if (s > MAXP) begin
                    pend = MAXP; m_ovf = 1;
                end else begin
                    pend = s;
                end
            end
        end
    endtask

    initial begin
        bit xf;
        repeat (2) @(posedge clk);
        started = 1;
        // single event
        step(0, 1, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        // three events in one cycle
        step(0, 3, 0, 0);
        repeat (12) step(0, 0, 0, 0);
        // pending 4 held off by xfull
        step(0, 3, 0, 1);
        step(0, 1, 0, 1);
        repeat (9) step(0, 0, 0, 1);
        repeat (16) step(0, 0, 0, 0);
        // saturation then drain
        repeat (6) step(0, 3, 0, 1);
        repeat (50) step(0, 0, 0, 0);
        // flush with same-cycle events, pulse in flight
        step(0, 3, 0, 0);
        step(0, 2, 0, 0);
        step(0, 2, 1, 0);
        repeat (8) step(0, 0, 0, 0);
        // reset mid-burst while in GAP
        step(0, 3, 0, 0);
        step(0, 3, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(1, 3, 1, 0);
        repeat (6) step(0, 0, 0, 0);
        // randomized traffic
        xf = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) xf = ~xf;
            step($urandom_range(0, 299) == 0,
                 ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3)),
                 $urandom_range(0, 39) == 0,
                 xf);
        end
        repeat (80) step(0, 0, 0, 0);
        chk("queue_empty", exp_q.size(), 0);
        chk("final_pending", int'(pending), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
